// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter.
// No logic; no latency.
// No flow control.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } alu_arb_state_t;

    localparam int FLAG_Z  = 0;
    localparam int FLAG_N  = 1;
    localparam int FLAG_C  = 2;
    localparam int FLAG_V  = 3;
    localparam int MAX_REQ = 4;

endpackage

// File: rtl/alu.sv
// Four-bit ALU: sel 00 add, 01 sub, 10 and, 11 xor of A with zero-extended B.
// Purely combinational, zero latency.
// No flow control.
module alu (
    input  logic [3:0] a,
    input  logic [1:0] b,
    input  logic [1:0] sel,
    output logic [3:0] y,
    output logic       z,
    output logic       n,
    output logic       c,
    output logic       v
);
    logic [3:0] bx;
    logic [4:0] sum;

    always_comb begin
        bx  = {2'b00, b};
        sum = '0;
        y   = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (sel)
            2'b00: begin
                sum = {1'b0, a} + {1'b0, bx};
                y   = sum[3:0];
                c   = sum[4];
                v   = (a[3] == bx[3]) && (y[3] != a[3]);
            end
            2'b01: begin
                // c is the not-borrow carry of a + ~b + 1
                sum = {1'b0, a} + {1'b0, ~bx} + 5'd1;
                y   = sum[3:0];
                c   = sum[4];
                v   = (a[3] != bx[3]) && (y[3] != a[3]);
            end
            2'b10:   y = a & bx;
            default: y = a ^ bx;
        endcase
        z = (y == 4'd0);
        n = y[3];
    end
endmodule

// File: rtl/alu_arb_grant.sv
// One-hot request picker; round-robin after the pointer when ALU_ARB_RR_EN, else lowest index.
// Combinational, zero latency.
// No flow control; grant is zero when no request is valid.
module alu_arb_grant
    import alu_arb_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] valid,
`ifdef ALU_ARB_RR_EN
    input  logic [1:0]       ptr,
`endif
    output logic [N_REQ-1:0] grant,
    output logic [1:0]       idx
);
    always_comb begin
        logic found;
        found = 1'b0;
        grant = '0;
        idx   = '0;
`ifdef ALU_ARB_RR_EN
        // Indices above the last winner outrank those at or below it.
        for (int i = 0; i < N_REQ && i < MAX_REQ; i++) begin
            if (!found && valid[i] && i > int'(ptr)) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                idx      = 2'(i);
            end
        end
        for (int i = 0; i < N_REQ && i < MAX_REQ; i++) begin
            if (!found && valid[i] && i <= int'(ptr)) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                idx      = 2'(i);
            end
        end
`else
        for (int i = 0; i < N_REQ && i < MAX_REQ; i++) begin
            if (!found && valid[i]) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                idx      = 2'(i);
            end
        end
`endif
    end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between N_REQ requesters (round-robin if ALU_ARB_RR_EN, else fixed priority).
// Latency: grant edge k, response valid after edge k+1; one transaction per 3 cycles at best.
// Backpressure: response held until rsp_ready; req_ready stays low outside IDLE.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [4*N_REQ-1:0] req_a,
    input  logic [2*N_REQ-1:0] req_b,
    input  logic [2*N_REQ-1:0] req_sel,
    output logic [N_REQ-1:0]   req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [3:0]         rsp_y,
    output logic [3:0]         rsp_flags,
    output logic [1:0]         rsp_id,
    output logic               busy
);
    alu_arb_state_t   state;
    logic [N_REQ-1:0] grant;
    logic [1:0]       gidx;
    logic             accept;
    logic [3:0]       win_a;
    logic [1:0]       win_b;
    logic [1:0]       win_sel;
    logic [3:0]       op_a;
    logic [1:0]       op_b;
    logic [1:0]       op_sel;
    logic [1:0]       op_id;
    logic [3:0]       alu_y;
    logic [3:0]       alu_flags;
    logic             alu_z;
    logic             alu_n;
    logic             alu_c;
    logic             alu_v;
`ifdef ALU_ARB_RR_EN
    logic [1:0]       ptr;
`endif

    alu_arb_grant #(.N_REQ(N_REQ)) u_grant (
        .valid (req_valid),
`ifdef ALU_ARB_RR_EN
        .ptr   (ptr),
`endif
        .grant (grant),
        .idx   (gidx)
    );

    assign accept    = (state == IDLE) && (|req_valid);
    // Gated by rst so the grant drops immediately on an asynchronous reset.
    assign req_ready = (state == IDLE && !rst) ? grant : '0;
    assign busy      = (state != IDLE);

    always_comb begin
        win_a   = '0;
        win_b   = '0;
        win_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                win_a   = req_a[4*i +: 4];
                win_b   = req_b[2*i +: 2];
                win_sel = req_sel[2*i +: 2];
            end
        end
    end

    alu u_alu (
        .a   (op_a),
        .b   (op_b),
        .sel (op_sel),
        .y   (alu_y),
        .z   (alu_z),
        .n   (alu_n),
        .c   (alu_c),
        .v   (alu_v)
    );

    always_comb begin
        alu_flags         = '0;
        alu_flags[FLAG_Z] = alu_z;
        alu_flags[FLAG_N] = alu_n;
        alu_flags[FLAG_C] = alu_c;
        alu_flags[FLAG_V] = alu_v;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            op_sel    <= '0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_y     <= '0;
            rsp_flags <= '0;
            rsp_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a   <= win_a;
                        op_b   <= win_b;
                        op_sel <= win_sel;
                        op_id  <= gidx;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_y     <= alu_y;
                    rsp_flags <= alu_flags;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 2'(N_REQ - 1);
        end else if (accept) begin
            ptr <= gidx;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with four requesters; expectations follow ALU_ARB_RR_EN.
module tb_alu_arbiter;
    localparam int N = 4;

    typedef struct {
        int         id;
        logic [3:0] a;
        logic [1:0] b;
        logic [1:0] sel;
        logic [3:0] y;
        logic [3:0] f;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [4*N-1:0] req_a = '0;
    logic [2*N-1:0] req_b = '0;
    logic [2*N-1:0] req_sel = '0;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [3:0]     rsp_y;
    logic [3:0]     rsp_flags;
    logic [1:0]     rsp_id;
    logic           busy;

    int n_pass  = 0;
    int n_total = 0;

    alu_arbiter #(.N_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_flags (rsp_flags),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [3:0] a, input logic [1:0] b,
                           input logic [1:0] sel);
        req_a[4*id +: 4]   = a;
        req_b[2*id +: 2]   = b;
        req_sel[2*id +: 2] = sel;
    endtask

    task automatic expect_rsp(input logic [1:0] id, input string nm);
        int cnt = 0;
        while (!rsp_valid && cnt < 8) begin
            tick();
            cnt++;
        end
        chk({nm, "_vld"}, 16'(rsp_valid), 16'd1);
        chk({nm, "_id"}, 16'(rsp_id), 16'(id));
        tick();
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #3 rst = 1'b0;
        tick();
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_rsp_valid"}, 16'(rsp_valid), 16'd0);
        chk({nm, "_rsp_y"}, 16'(rsp_y), 16'd0);
        chk({nm, "_rsp_flags"}, 16'(rsp_flags), 16'd0);
        chk({nm, "_rsp_id"}, 16'(rsp_id), 16'd0);
        chk({nm, "_busy"}, 16'(busy), 16'd0);
        chk({nm, "_req_ready"}, 16'(req_ready), 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        vecs[0] = '{0, 4'h7, 2'd1, 2'b00, 4'h8, 4'b1010};
        vecs[1] = '{1, 4'hF, 2'd1, 2'b00, 4'h0, 4'b0101};
        vecs[2] = '{2, 4'h3, 2'd3, 2'b01, 4'h0, 4'b0101};
        vecs[3] = '{3, 4'h1, 2'd2, 2'b01, 4'hF, 4'b0010};
        vecs[4] = '{0, 4'h8, 2'd1, 2'b01, 4'h7, 4'b1100};
        vecs[5] = '{1, 4'hE, 2'd3, 2'b10, 4'h2, 4'b0000};
        vecs[6] = '{2, 4'h5, 2'd3, 2'b11, 4'h6, 4'b0000};
        vecs[7] = '{3, 4'hC, 2'd0, 2'b11, 4'hC, 4'b0010};
        vecs[8] = '{0, 4'h4, 2'd2, 2'b10, 4'h0, 4'b0001};

        // Reset state, including a valid request that must not be granted.
        req_valid = 4'b0001;
        #2;
        chk_zero("reset");
        req_valid = '0;
        #10 rst = 1'b0;
        tick();
        chk("post_reset_busy", 16'(busy), 16'd0);

        // Single transactions with rsp_ready high.
        rsp_ready = 1'b1;
        foreach (vecs[k]) begin
            set_req(vecs[k].id, vecs[k].a, vecs[k].b, vecs[k].sel);
            req_valid = 4'(1) << vecs[k].id;
            #1;
            chk($sformatf("v%0d_grant", k), 16'(req_ready), 16'(4'(1) << vecs[k].id));
            tick();
            req_valid = '0;
            chk($sformatf("v%0d_exec_busy", k), 16'(busy), 16'd1);
            chk($sformatf("v%0d_exec_rdy", k), 16'(req_ready), 16'd0);
            tick();
            chk($sformatf("v%0d_vld", k), 16'(rsp_valid), 16'd1);
            chk($sformatf("v%0d_y", k), 16'(rsp_y), 16'(vecs[k].y));
            chk($sformatf("v%0d_flags", k), 16'(rsp_flags), 16'(vecs[k].f));
            chk($sformatf("v%0d_id", k), 16'(rsp_id), 16'(vecs[k].id));
            tick();
            chk($sformatf("v%0d_done_vld", k), 16'(rsp_valid), 16'd0);
            chk($sformatf("v%0d_done_busy", k), 16'(busy), 16'd0);
        end

        // Response held under backpressure while another requester waits.
        rsp_ready = 1'b0;
        set_req(1, 4'h9, 2'd3, 2'b01);
        req_valid = 4'b0010;
        tick();
        set_req(3, 4'h1, 2'd1, 2'b00);
        req_valid = 4'b1000;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("hold_vld", 16'(rsp_valid), 16'd1);
            chk("hold_y", 16'(rsp_y), 16'h6);
            chk("hold_flags", 16'(rsp_flags), 16'b1100);
            chk("hold_id", 16'(rsp_id), 16'd1);
            chk("hold_req_ready", 16'(req_ready), 16'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("release_vld", 16'(rsp_valid), 16'd0);
        chk("release_busy", 16'(busy), 16'd0);
        chk("release_grant", 16'(req_ready), 16'b1000);
        tick();
        req_valid = '0;
        tick();
        chk("waiter_y", 16'(rsp_y), 16'h2);
        chk("waiter_id", 16'(rsp_id), 16'd3);
        tick();

        // Two requesters continuously valid.
        do_reset();
        set_req(0, 4'h1, 2'd0, 2'b00);
        set_req(1, 4'h2, 2'd0, 2'b00);
        req_valid = 4'b0011;
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_RR_EN
            expect_rsp(2'(k % 2), $sformatf("alt%0d", k));
`else
            expect_rsp(2'd0, $sformatf("alt%0d", k));
`endif
        end
        req_valid = '0;
        tick();

        // Sparse requesters 1 and 3, last grant 3.
        do_reset();
        req_valid = 4'b1000;
        expect_rsp(2'd3, "sparse_first");
        req_valid = 4'b1010;
        expect_rsp(2'd1, "sparse_second");
`ifdef ALU_ARB_RR_EN
        expect_rsp(2'd3, "sparse_third");
`else
        expect_rsp(2'd1, "sparse_third");
`endif
        req_valid = '0;
        tick();

        // Requester drops valid before being granted.
        rsp_ready = 1'b0;
        set_req(0, 4'h1, 2'd1, 2'b00);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        tick();
        chk("drop_owner_id", 16'(rsp_id), 16'd0);
        req_valid = 4'b0100;
        tick();
        chk("drop_rdy_resp", 16'(req_ready), 16'd0);
        tick();
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("drop_idle_busy", 16'(busy), 16'd0);
            chk("drop_idle_vld", 16'(rsp_valid), 16'd0);
            tick();
        end
        req_valid = 4'b0001;
        expect_rsp(2'd0, "drop_next");
        req_valid = '0;
        tick();

        // Asynchronous reset in EXEC and in RESP.
        rsp_ready = 1'b0;
        set_req(1, 4'h7, 2'd1, 2'b00);
        req_valid = 4'b0010;
        tick();
        #1 rst = 1'b1;
        #1;
        chk_zero("rst_exec");
        #1 rst = 1'b0;
        #1;
        chk("rst_exec_regrant", 16'(req_ready), 16'b0010);
        tick();
        req_valid = '0;
        tick();
        chk("pre_rst_resp_vld", 16'(rsp_valid), 16'd1);
        chk("pre_rst_resp_y", 16'(rsp_y), 16'h8);
        #1 rst = 1'b1;
        #1;
        chk_zero("rst_resp");
        set_req(0, 4'h2, 2'd2, 2'b00);
        set_req(2, 4'h3, 2'd1, 2'b00);
        req_valid = 4'b0101;
        #1 rst = 1'b0;
        #1;
        chk("post_rst_grant", 16'(req_ready), 16'b0001);
        rsp_ready = 1'b1;
        expect_rsp(2'd0, "post_rst");
        req_valid = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
